// File: rtl/ca90_item_gen_ctrl_pkg.sv
// Shared types for the CA90 item generator controller.
package ca90_item_gen_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int unsigned CA90_SHIFT = 1;

endpackage

// File: rtl/ca90_item_gen_ctrl_ca90_unit.sv
// One full-width CA90 step: each bit becomes the XOR of its two neighbours at
// distance shift_amt_i, with cyclic wrap-around.
module ca90_unit #(
  parameter int unsigned Dimension = 512,
  parameter int unsigned ShiftW    = $clog2(Dimension)
) (
  input  logic [Dimension-1:0] hv_i,
  input  logic [ShiftW-1:0]    shift_amt_i,
  output logic [Dimension-1:0] hv_o
);

  logic [2*Dimension-1:0] dbl;
  logic [2*Dimension-1:0] dbl_l;
  logic [2*Dimension-1:0] dbl_r;

  // Rotations come from shifting a doubled copy and taking the matching half.
  always_comb begin
    dbl   = {hv_i, hv_i};
    dbl_l = dbl << shift_amt_i;
    dbl_r = dbl >> shift_amt_i;
    hv_o  = dbl_l[2*Dimension-1:Dimension] ^ dbl_r[Dimension-1:0];
  end

endmodule

// File: rtl/ca90_item_gen_ctrl.sv
// Produces CA90^k(base) item hypervectors, continuing from the cached result
// when indices increase monotonically.
//
// state | meaning
// IDLE  | ready for a request; result (if any) stays cached in hv_q
// STEP  | one CA90 step per cycle until remain_q reaches zero
// OUT   | item_hv_o valid, held until item_ready_i
module ca90_item_gen_ctrl
  import ca90_item_gen_ctrl_pkg::*;
#(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned NumItems    = 1024,
  parameter int unsigned IdxWidth    = $clog2(NumItems)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [HVDimension-1:0] base_hv_i,
  input  logic                   invalidate_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [IdxWidth-1:0]    req_idx_i,
  output logic                   item_valid_o,
  input  logic                   item_ready_i,
  output logic [HVDimension-1:0] item_hv_o,
  output logic [IdxWidth-1:0]    item_idx_o,
  output logic                   busy_o
);

  localparam int unsigned ShiftW = $clog2(HVDimension);

  state_e                   state_q;
  logic [HVDimension-1:0]   hv_q;
  logic [HVDimension-1:0]   hv_step;
  logic [IdxWidth-1:0]      cur_idx_q;
  logic [IdxWidth-1:0]      remain_q;
  logic                     cache_vld_q;
  logic                     accept;
  logic                     cont;
  logic [IdxWidth-1:0]      remain_next;

  ca90_unit #(
    .Dimension (HVDimension),
    .ShiftW    (ShiftW)
  ) u_ca90 (
    .hv_i        (hv_q),
    .shift_amt_i (ShiftW'(CA90_SHIFT)),
    .hv_o        (hv_step)
  );

  assign accept      = (state_q == ST_IDLE) && req_valid_i;
  assign cont        = cache_vld_q && !invalidate_i && (req_idx_i >= cur_idx_q);
  assign remain_next = cont ? (req_idx_i - cur_idx_q) : req_idx_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      hv_q        <= '0;
      cur_idx_q   <= '0;
      remain_q    <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      if (invalidate_i) cache_vld_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            remain_q <= remain_next;
            if (!cont) begin
              // Restart wins over a same-cycle invalidate: the new base is loaded.
              hv_q        <= base_hv_i;
              cur_idx_q   <= '0;
              cache_vld_q <= 1'b1;
            end
            state_q <= (remain_next == '0) ? ST_OUT : ST_STEP;
          end
        end
        ST_STEP: begin
          hv_q      <= hv_step;
          cur_idx_q <= cur_idx_q + IdxWidth'(1);
          remain_q  <= remain_q - IdxWidth'(1);
          if (remain_q == IdxWidth'(1)) state_q <= ST_OUT;
        end
        ST_OUT: begin
          if (item_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign item_valid_o = (state_q == ST_OUT);
  assign busy_o       = (state_q != ST_IDLE);
  assign item_hv_o    = hv_q;
  assign item_idx_o   = cur_idx_q;

endmodule
